// File: rtl/gcd_dispatch.sv
// Front end for the binary GCD core: queues operand pairs, issues one job at a
// time with a single-cycle load pulse and returns each result on a valid/ready port.
module gcd_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic             core_ld,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] memA_q [DEPTH];
  logic [WIDTH-1:0] memB_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] opA_q, opA_d, opB_q, opB_d;
  logic [WIDTH-1:0] outGcd_q, outGcd_d;
  logic             outZero_q, outZero_d;
  logic             push, pop;
  logic [WIDTH-1:0] headA, headB;

  assign in_ready = (count_q != Full);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign headA    = memA_q[rdPtr_q];
  assign headB    = memB_q[rdPtr_q];

  assign core_a   = opA_q;
  assign core_b   = opB_q;
  assign out_gcd  = outGcd_q;
  assign out_zero = outZero_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q] <= in_a;
      memB_q[wrPtr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      outGcd_q  <= '0;
      outZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      outGcd_q  <= outGcd_d;
      outZero_q <= outZero_d;
    end
  end

  // Zero operands never terminate in the binary core, so they bypass it:
  // gcd(0,x)=x and gcd(0,0) is reported as 0 with out_zero set.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    outGcd_d  = outGcd_q;
    outZero_d = outZero_q;
    core_ld   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          opA_d = headA;
          opB_d = headB;
          if (headA != '0 && headB != '0) begin
            state_d = ISSUE;
          end else begin
            state_d   = HOLD;
            outGcd_d  = headA | headB;
            outZero_d = (headA == '0) && (headB == '0);
          end
        end
      end
      ISSUE: begin
        core_ld = core_ready;
        if (core_ready) state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          outGcd_d  = core_result;
          outZero_d = 1'b0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: behavioural core model, scoreboard queue filled at
// push time and drained by an independent output monitor.
module tb_gcd_dispatch;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_zero;
  logic         core_ld;
  logic [W-1:0] core_a, core_b;
  logic         core_ready;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         busy;

  typedef struct {
    logic [W-1:0] g;
    logic         z;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   ldCount = 0;
  int   resultCount = 0;

  logic randMode = 1'b0;
  logic readyForce = 1'b1;
  logic rndReady = 1'b1;
  logic stallReady = 1'b0;
  logic stallRnd = 1'b0;
  logic injectDone = 1'b0;
  int   coreLat = 3;

  logic         coreBusy, coreDone;
  int           coreCnt;
  logic [W-1:0] capA, capB, coreRes;

  gcd_dispatch #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_zero(out_zero),
    .core_ld(core_ld), .core_a(core_a), .core_b(core_b),
    .core_ready(core_ready), .core_done(core_done), .core_result(core_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural core: accepts a load while ready, then pulses done after a latency.
  always @(posedge clk) begin
    if (reset) begin
      coreBusy <= 1'b0;
      coreDone <= 1'b0;
      coreCnt  <= 0;
      capA     <= '0;
      capB     <= '0;
      coreRes  <= '0;
    end else begin
      coreDone <= 1'b0;
      if (core_ld && !coreBusy) begin
        coreBusy <= 1'b1;
        capA     <= core_a;
        capB     <= core_b;
        coreCnt  <= randMode ? int'($urandom_range(1, 6)) : coreLat;
      end else if (coreBusy) begin
        if (coreCnt <= 1) begin
          coreBusy <= 1'b0;
          coreDone <= 1'b1;
          coreRes  <= refGcd(capA, capB);
        end else begin
          coreCnt <= coreCnt - 1;
        end
      end
    end
  end

  assign core_ready  = !coreBusy && !coreDone && !(randMode ? stallRnd : stallReady);
  assign core_done   = coreDone | injectDone;
  assign core_result = injectDone ? 32'hDEAD : coreRes;
  assign out_ready   = randMode ? rndReady : readyForce;

  initial forever begin
    @(negedge clk);
    rndReady = ($urandom_range(0, 2) != 0);
    stallRnd = ($urandom_range(0, 3) == 0);
  end

  // Output monitor: pops the scoreboard on each handshake and checks that a
  // stalled result stays put; also polices the load pulse.
  initial begin
    logic         holdPrev;
    logic         prevLd;
    logic [W-1:0] prevGcd;
    logic         prevZero;
    exp_t         e;
    holdPrev = 1'b0;
    prevLd   = 1'b0;
    prevGcd  = '0;
    prevZero = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        holdPrev = 1'b0;
        prevLd   = 1'b0;
      end else begin
        if (core_ld) begin
          ldCount++;
          checkOutput("ld_needs_ready", 32'(core_ready), 32'd1);
          checkOutput("ld_single_cycle", 32'(prevLd), 32'd0);
        end
        prevLd = core_ld;
        if (coreDone && !injectDone) begin
          checkOutput("core_a_stable", core_a, capA);
          checkOutput("core_b_stable", core_b, capB);
        end
        if (holdPrev) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_gcd", out_gcd, prevGcd);
          checkOutput("hold_zero", 32'(out_zero), 32'(prevZero));
        end
        holdPrev = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
              e = expQ.pop_front();
              checkOutput("out_gcd", out_gcd, e.g);
              checkOutput("out_zero", 32'(out_zero), 32'(e.z));
              resultCount++;
            end
          end else begin
            holdPrev = 1'b1;
            prevGcd  = out_gcd;
            prevZero = out_zero;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.g = refGcd(a, b);
      e.z = (a == 0) && (b == 0);
      expQ.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  function automatic logic sigVal(input int which);
    case (which)
      0:       return core_ld;
      1:       return out_valid;
      default: return !busy && expQ.size() == 0;
    endcase
  endfunction

  // Counts falling edges until the selected condition holds; 0=core_ld, 1=out_valid, 2=idle.
  task automatic waitSig(input int which, input int maxCycles, output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!sigVal(which) && n < maxCycles);
    if (!sigVal(which)) checkOutput($sformatf("wait_timeout_%0d", which), 32'(sigVal(which)), 32'd1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, ldBase, resBase, accepted, stallLd, lateSeen, pushes;
    logic acceptNow;
    logic [W-1:0] pa [6];
    logic [W-1:0] pb [6];
    logic [W-1:0] ra, rb, k;
    pa = '{32'd12, 32'd7, 32'd8, 32'd48, 32'd100, 32'd1};
    pb = '{32'd18, 32'd13, 32'd8, 32'd36, 32'd75, 32'd1};

    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_gcd", out_gcd, 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
    checkOutput("rst_core_ld", 32'(core_ld), 32'd0);
    checkOutput("rst_core_a", core_a, 32'd0);
    checkOutput("rst_core_b", core_b, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] nonzero job (12,18)");
    readyForce = 1'b1;
    coreLat = 3;
    ldBase = ldCount;
    applyStimulus(32'd12, 32'd18);
    waitSig(0, 20, n);
    checkOutput("ld_latency", n, 32'd2);
    checkOutput("ld_core_a", core_a, 32'd12);
    checkOutput("ld_core_b", core_b, 32'd18);
    waitSig(1, 30, n);
    @(negedge clk);
    #1;
    checkOutput("busy_after_handshake", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("one_ld_pulse", ldCount - ldBase, 32'd1);

    $display("[TB] zero bypass jobs");
    ldBase = ldCount;
    applyStimulus(32'd0, 32'd7);
    waitSig(1, 20, n);
    checkOutput("bypass_latency_a0", n, 32'd2);
    waitSig(2, 20, n);
    applyStimulus(32'd9, 32'd0);
    waitSig(1, 20, n);
    checkOutput("bypass_latency_b0", n, 32'd2);
    waitSig(2, 20, n);
    applyStimulus(32'd0, 32'd0);
    waitSig(1, 20, n);
    checkOutput("bypass_latency_00", n, 32'd2);
    checkOutput("bypass_zero_flag", 32'(out_zero), 32'd1);
    waitSig(2, 20, n);
    checkOutput("bypass_no_ld", ldCount - ldBase, 32'd0);

    $display("[TB] backpressure with full FIFO");
    readyForce = 1'b0;
    resBase = resultCount;
    accepted = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = pa[accepted];
      in_b = pb[accepted];
      acceptNow = in_ready;
      @(posedge clk);
      if (acceptNow) begin
        expQ.push_back('{refGcd(pa[accepted], pb[accepted]), 1'b0});
        accepted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("bp_accepted", accepted, 32'd5);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    waitSig(1, 30, n);
    repeat (5) @(negedge clk);
    readyForce = 1'b1;
    waitSig(2, 200, n);
    checkOutput("bp_results", resultCount - resBase, 32'd5);

    $display("[TB] core_ready stall");
    stallReady = 1'b1;
    ldBase = ldCount;
    stallLd = 0;
    applyStimulus(32'd15, 32'd10);
    repeat (12) begin
      @(negedge clk);
      #1;
      if (core_ld) stallLd++;
    end
    checkOutput("stall_no_ld", stallLd, 32'd0);
    @(negedge clk);
    stallReady = 1'b0;
    #1;
    checkOutput("ld_on_ready", 32'(core_ld), 32'd1);
    waitSig(2, 50, n);
    checkOutput("stall_one_ld", ldCount - ldBase, 32'd1);

    $display("[TB] reset during WAIT");
    coreLat = 30;
    applyStimulus(32'd40, 32'd24);
    waitSig(0, 20, n);
    applyStimulus(32'd5, 32'd3);
    applyStimulus(32'd9, 32'd6);
    @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    injectDone = 1'b1;
    @(negedge clk);
    injectDone = 1'b0;
    lateSeen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid || busy) lateSeen++;
    end
    checkOutput("late_done_ignored", lateSeen, 32'd0);
    coreLat = 3;
    resBase = resultCount;
    applyStimulus(32'd21, 32'd14);
    waitSig(2, 50, n);
    checkOutput("post_reset_result", resultCount - resBase, 32'd1);

    $display("[TB] randomized jobs");
    randMode = 1'b1;
    resBase = resultCount;
    pushes = 0;
    for (int j = 0; j < 40; j++) begin
      k = $urandom_range(1, 40);
      case ($urandom_range(0, 3))
        0: begin ra = 0; rb = $urandom_range(0, 300); end
        1: begin ra = $urandom_range(1, 200); rb = $urandom_range(1, 200); end
        2: begin ra = $urandom; rb = $urandom; end
        default: begin ra = k * $urandom_range(1, 60); rb = k * $urandom_range(1, 60); end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        {ra, rb} = {rb, ra};
      end
      applyStimulus(ra, rb);
      pushes++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    randMode = 1'b0;
    readyForce = 1'b1;
    waitSig(2, 2000, n);
    checkOutput("random_results", resultCount - resBase, pushes);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_dispatch.md
Name: gcd_dispatch

Overview:
- Front-end stage that sits directly upstream and downstream of the GCD core controller/datapath.
- Buffers incoming operand pairs in a small FIFO and issues one job at a time to the core with a single-cycle load pulse.
- Captures the core result when the core signals done and presents it on a valid/ready output.
- Screens zero operands, which the binary GCD core does not terminate on, and resolves them locally without using the core.

Parameters:
WIDTH, 32, operand and result width in bits
DEPTH, 4, operand FIFO entries; power of 2, at least 2

Ports:
clk  input  1  clock; all logic is rising-edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept a pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_gcd  output  WIDTH  GCD result
out_zero  output  1  both operands were zero; out_gcd is 0
core_ld  output  1  load pulse to core (core ld_i)
core_a  output  WIDTH  operand A to core
core_b  output  WIDTH  operand B to core
core_ready  input  1  core in READY state
core_done  input  1  core in DONE state (one-cycle pulse)
core_result  input  WIDTH  core GCD value, valid while core_done
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high.
- Reset values (applied by a synchronous active-high reset):
  - FIFO pointers and count are 0.
  - FSM is IDLE.
  - in_ready=1; out_valid=0; out_gcd=0; out_zero=0; core_ld=0; core_a=0; core_b=0; busy=0.
- Reset mid-operation:
  - Any queued or in-flight job is discarded.
  - The core shares the same reset.
  - core_done arriving after reset is ignored because the FSM is IDLE.
- FIFO:
  - Push when in_valid && in_ready, where in_ready = (count != DEPTH).
  - Pop occurs only in IDLE.
  - Simultaneous push and pop is allowed; count is unchanged in that case.
  - Pointers wrap modulo DEPTH.
  - No push when full; no pop when empty.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop the head into op_a/op_b (which drive core_a/core_b).
  - Next state:
    - ISSUE if op_a != 0 and op_b != 0.
    - Otherwise HOLD, with out_gcd = op_a | op_b and out_zero = (op_a==0 && op_b==0).
    - Bypass case: out_valid is asserted the cycle after the pop, and core_ld is never asserted.
- ISSUE:
  - core_ld = core_ready (combinational, single cycle).
  - When core_ready=1, go to WAIT.
  - Otherwise stay in ISSUE with core_ld=0.
- WAIT:
  - core_a/core_b are held stable; the core samples them during its LOAD state.
  - On core_done: out_gcd <= core_result, out_zero <= 0, go to HOLD.
- HOLD:
  - out_valid=1; out_gcd and out_zero are stable.
  - On out_ready, go to IDLE.
  - The next pop happens in the following IDLE cycle, so throughput is at most 1 job per 2 cycles.
- Output rules:
  - out_valid is asserted only in HOLD.
  - core_ld is asserted only in ISSUE.
  - core_done outside WAIT is ignored.
- Only one job is outstanding at a time. Results are returned in input order.
- Latency, nonzero job from push into an empty FIFO with the core ready:
  - push at t, IDLE pop at t+1, ISSUE/core_ld at t+2, WAIT from t+3.
  - out_valid is asserted the cycle after core_done.
- Latency, zero bypass: push at t, pop at t+1, out_valid at t+2.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Push (12,18); out_ready=1 -> exactly one core_ld pulse with core_a=12, core_b=18; after core_done, out_valid with out_gcd=6, out_zero=0; busy drops 1 cycle after handshake.
- Push (0,7), then (9,0) -> out_gcd=7, then 9; no core_ld; each out_valid appears 2 cycles after its push.
- Push (0,0) -> out_gcd=0, out_zero=1; no core_ld.
- DEPTH=4; out_ready=0; push continuously:
  - 5 pairs are accepted (1 in HOLD, 4 queued), then in_ready=0.
  - out_valid and out_gcd stay stable.
  - Release out_ready -> all 5 results in order; e.g. (12,18)=6, (7,13)=1, (8,8)=8, (48,36)=12, (100,75)=25.
- Hold core_ready=0 for 10 cycles in ISSUE -> core_ld stays 0; the pulse appears in the first cycle core_ready=1, and only once.
- Assert reset during WAIT with 2 jobs queued -> next cycle out_valid=0, busy=0, in_ready=1; a late core_done yields no output; a new pair (21,14) then returns 7.
